// File: rtl/sm_trace_pkg.sv
// Shared encodings for the schoolRISCV per-commit trace monitor.
package sm_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STOPPED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_TIMEOUT = 2'd1,
        CAUSE_HALT    = 2'd2,
        CAUSE_BREAK   = 2'd3
    } cause_e;

    // Packed entry layout, MSB first: {cycle, pc, instr, a0}
    function automatic int entry_width(input int cw, input int pw, input int dw);
        return cw + pw + 2 * dw;
    endfunction

endpackage

// File: rtl/sm_trace_buf.sv
// Circular trace buffer: overwrites the oldest entry when full and flags it stickily.
module sm_trace_buf
    import sm_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 112
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, do_rd;

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        full       = (count_q == CNT_W'(DEPTH));
        do_rd      = rd_en && (count_q != '0);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                // Full without a pop: drop the oldest entry by dragging rd_ptr along
                if (full && !do_rd) begin
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    overflow_d = 1'b1;
                end else if (!do_rd) begin
                    count_d = count_q + 1'b1;
                end
            end else if (do_rd) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    assign rd_data  = mem[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/sm_trace_monitor.sv
// Per-commit trace monitor: captures commits while running, stops on break/halt/timeout, then drains oldest-first.
module sm_trace_monitor
    import sm_trace_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int PC_WIDTH       = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CYCLE_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 120,
    parameter int STALL_LIMIT    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      commit_valid,
    input  logic [PC_WIDTH-1:0]       commit_pc,
    input  logic [DATA_WIDTH-1:0]     commit_instr,
    input  logic [DATA_WIDTH-1:0]     commit_a0,
    input  logic                      arm,
    input  logic                      clear,
    input  logic                      break_en,
    input  logic [PC_WIDTH-1:0]       break_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CYCLE_WIDTH-1:0]    out_cycle,
    output logic [PC_WIDTH-1:0]       out_pc,
    output logic [DATA_WIDTH-1:0]     out_instr,
    output logic [DATA_WIDTH-1:0]     out_a0,
    output logic [1:0]                state,
    output logic [1:0]                stop_cause,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [CYCLE_WIDTH-1:0]    cycle
);
    localparam int EW    = entry_width(CYCLE_WIDTH, PC_WIDTH, DATA_WIDTH);
    localparam int RPT_W = $clog2(STALL_LIMIT + 2);

    state_e                 state_q, state_d;
    cause_e                 cause_q, cause_d;
    logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
    logic [PC_WIDTH-1:0]    prev_pc_q, prev_pc_d;
    logic                   have_prev_q, have_prev_d;
    logic [RPT_W-1:0]       rpt_q, rpt_d;

    logic                   capture, pop;
    logic                   is_repeat, break_hit, halt_hit, timeout_hit;
    logic [EW-1:0]          rd_entry;
    logic [$clog2(DEPTH):0] buf_count;

    sm_trace_buf #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (clear),
        .wr_en    (capture),
        .wr_data  ({cycle_q, commit_pc, commit_instr, commit_a0}),
        .rd_en    (pop),
        .rd_data  (rd_entry),
        .count    (buf_count),
        .overflow (overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cause_q     <= CAUSE_NONE;
            cycle_q     <= '0;
            prev_pc_q   <= '0;
            have_prev_q <= 1'b0;
            rpt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            cycle_q     <= cycle_d;
            prev_pc_q   <= prev_pc_d;
            have_prev_q <= have_prev_d;
            rpt_q       <= rpt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        cycle_d     = cycle_q;
        prev_pc_d   = prev_pc_q;
        have_prev_d = have_prev_q;
        rpt_d       = rpt_q;
        capture     = 1'b0;
        // have_prev keeps the first commit after arm from counting as a repeat
        is_repeat   = have_prev_q && (commit_pc == prev_pc_q);
        break_hit   = break_en && commit_valid && (commit_pc == break_pc);
        halt_hit    = (STALL_LIMIT != 0) && commit_valid && is_repeat &&
                      (rpt_q + 1'b1 == RPT_W'(STALL_LIMIT));
        timeout_hit = (TIMEOUT_CYCLES != 0) &&
                      (cycle_q + 1'b1 == CYCLE_WIDTH'(TIMEOUT_CYCLES));
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d     = ST_RUN;
                    cycle_d     = '0;
                    rpt_d       = '0;
                    have_prev_d = 1'b0;
                end
            end
            ST_RUN: begin
                cycle_d = cycle_q + 1'b1;
                if (commit_valid) begin
                    capture     = 1'b1;
                    prev_pc_d   = commit_pc;
                    have_prev_d = 1'b1;
                    rpt_d       = is_repeat ? rpt_q + 1'b1 : '0;
                end
                if (break_hit) begin
                    state_d = ST_STOPPED;
                    cause_d = CAUSE_BREAK;
                end else if (halt_hit) begin
                    state_d = ST_STOPPED;
                    cause_d = CAUSE_HALT;
                end else if (timeout_hit) begin
                    state_d = ST_STOPPED;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            default: ;
        endcase
        if (clear) begin
            state_d     = ST_IDLE;
            cause_d     = CAUSE_NONE;
            cycle_d     = '0;
            prev_pc_d   = '0;
            have_prev_d = 1'b0;
            rpt_d       = '0;
            capture     = 1'b0;
        end
    end

    always_comb begin
        out_valid  = (state_q == ST_STOPPED) && (buf_count != '0);
        pop        = out_valid && out_ready;
        // Data is masked so the port reads zero whenever nothing is offered
        out_cycle  = '0;
        out_pc     = '0;
        out_instr  = '0;
        out_a0     = '0;
        if (out_valid) begin
            {out_cycle, out_pc, out_instr, out_a0} = rd_entry;
        end
        state      = state_q;
        stop_cause = cause_q;
        count      = buf_count;
        cycle      = cycle_q;
    end

endmodule

// File: tb/tb_sm_trace_monitor.sv
// Scoreboard bench for sm_trace_monitor: driver queues expected entries, a negedge monitor checks every pop.
module tb_sm_trace_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit_valid;
    logic [31:0] commit_pc, commit_instr, commit_a0;
    logic        arm, clear, break_en;
    logic [31:0] break_pc;
    logic        out_valid, out_ready;
    logic [15:0] out_cycle;
    logic [31:0] out_pc, out_instr, out_a0;
    logic [1:0]  st, cause;
    logic [4:0]  cnt;
    logic        ovf;
    logic [15:0] cyc;

    always #5 clk = ~clk;

    sm_trace_monitor #(
        .DEPTH(16), .PC_WIDTH(32), .DATA_WIDTH(32), .CYCLE_WIDTH(16),
        .TIMEOUT_CYCLES(120), .STALL_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_instr(commit_instr), .commit_a0(commit_a0), .arm(arm), .clear(clear),
        .break_en(break_en), .break_pc(break_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_cycle(out_cycle), .out_pc(out_pc), .out_instr(out_instr), .out_a0(out_a0),
        .state(st), .stop_cause(cause), .count(cnt), .overflow(ovf), .cycle(cyc)
    );

    typedef struct {
        logic [15:0] cyc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] a0;
    } entry_t;

    entry_t sb[$];
    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: every handshake pops the scoreboard; stalled entries must hold
    logic        hold_pending = 1'b0;
    logic [31:0] held_pc = '0;
    always @(negedge clk) begin
        entry_t e;
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) check("hold_stable", {out_valid, out_pc}, {1'b1, held_pc});
            if (out_valid) check("count_vs_sb", 64'(cnt), 64'(sb.size()));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL pop_unexpected: got pc 0x%0h, expected no entry", out_pc);
                end else begin
                    e = sb.pop_front();
                    check("out_cycle", 64'(out_cycle), 64'(e.cyc));
                    check("out_pc",    64'(out_pc),    64'(e.pc));
                    check("out_instr", 64'(out_instr), 64'(e.instr));
                    check("out_a0",    64'(out_a0),    64'(e.a0));
                end
            end
            hold_pending = out_valid && !out_ready;
            held_pc      = out_pc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [15:0] stamp, input bit kept);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_instr = pc + 32'h13;
        commit_a0    = pc * 3;
        if (kept) sb.push_back('{cyc: stamp, pc: pc, instr: pc + 32'h13, a0: pc * 3});
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic drain(input logic [3:0] pat, input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 400) begin
            out_ready = pat[k[1:0]];
            tick();
            k++;
        end
        out_ready = 1'b0;
        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL %s_drain_timeout: got %0d entries left, expected 0", tag, sb.size());
        end
        check({tag, "_valid_after_drain"}, 64'(out_valid), 64'd0);
        check({tag, "_state_after_drain"}, 64'(st), 64'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0; commit_valid = 1'b0; commit_pc = '0; commit_instr = '0; commit_a0 = '0;
        arm = 1'b0; clear = 1'b0; break_en = 1'b0; break_pc = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_state", 64'(st), 64'd0);
        check("rst_cause", 64'(cause), 64'd0);
        check("rst_count", 64'(cnt), 64'd0);
        check("rst_overflow", 64'(ovf), 64'd0);
        check("rst_out", {out_valid, out_pc, out_cycle}, 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: breakpoint after five sequential commits
        break_en = 1'b1; break_pc = 32'h10;
        do_arm();
        for (int i = 0; i < 5; i++) commit(32'(4 * i), 16'(i), 1'b1);
        check("t1_state", 64'(st), 64'd2);
        check("t1_cause", 64'(cause), 64'd3);
        check("t1_count", 64'(cnt), 64'd5);
        drain(4'b1111, "t1");
        do_clear();

        // 2: wrap the 16-entry buffer; oldest four entries are lost
        break_pc = 32'h4C;
        do_arm();
        for (int i = 0; i < 20; i++) commit(32'(4 * i), 16'(i), i >= 4);
        check("t2_count", 64'(cnt), 64'd16);
        check("t2_overflow", 64'(ovf), 64'd1);
        check("t2_first_pc", 64'(out_pc), 64'h10);
        drain(4'b1111, "t2");
        do_clear();
        check("t2_overflow_cleared", 64'(ovf), 64'd0);

        // 3: timeout with no commits
        break_en = 1'b0;
        do_arm();
        k = 0;
        while (st != 2'd2 && k < 300) begin tick(); k++; end
        check("t3_run_clocks", 64'(k), 64'd120);
        check("t3_cause", 64'(cause), 64'd1);
        check("t3_cycle", 64'(cyc), 64'd120);
        check("t3_count", 64'(cnt), 64'd0);
        check("t3_valid", 64'(out_valid), 64'd0);
        do_clear();

        // 4: branch-to-self halt, then an interrupted repeat run
        do_arm();
        commit(32'h8, 16'd0, 1'b1);
        for (int i = 1; i <= 4; i++) commit(32'h20, 16'(i), 1'b1);
        check("t4_still_run", 64'(st), 64'd1);
        commit(32'h20, 16'd5, 1'b1);
        check("t4_state", 64'(st), 64'd2);
        check("t4_cause", 64'(cause), 64'd2);
        check("t4_count", 64'(cnt), 64'd6);
        drain(4'b1111, "t4a");
        do_clear();
        do_arm();
        for (int i = 0; i < 3; i++) commit(32'h20, 16'(i), 1'b1);
        commit(32'h24, 16'd3, 1'b1);
        for (int i = 4; i < 8; i++) commit(32'h20, 16'(i), 1'b1);
        check("t4_interrupted_run", 64'(st), 64'd1);
        check("t4_interrupted_count", 64'(cnt), 64'd8);
        commit(32'h20, 16'd8, 1'b1);
        check("t4b_cause", 64'(cause), 64'd2);
        drain(4'b1111, "t4b");
        do_clear();

        // 5a: breakpoint on the timeout edge wins
        break_en = 1'b1; break_pc = 32'h40;
        do_arm();
        repeat (119) tick();
        commit(32'h40, 16'd119, 1'b1);
        check("t5_cause", 64'(cause), 64'd3);
        check("t5_cycle", 64'(cyc), 64'd120);
        check("t5_count", 64'(cnt), 64'd1);
        drain(4'b1111, "t5");

        // 5b: clear beats arm
        clear = 1'b1; arm = 1'b1;
        tick();
        clear = 1'b0; arm = 1'b0;
        check("t5_clear_arm_state", 64'(st), 64'd0);
        check("t5_clear_arm_cause", 64'(cause), 64'd0);

        // 5c: asynchronous reset in the middle of a drain
        break_pc = 32'h108;
        do_arm();
        for (int i = 0; i < 3; i++) commit(32'(32'h100 + 4 * i), 16'(i), 1'b1);
        check("t5c_count", 64'(cnt), 64'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5c_rst_state", 64'(st), 64'd0);
        check("t5c_rst_count", 64'(cnt), 64'd0);
        check("t5c_rst_out", {out_valid, out_pc, out_cycle}, 64'd0);
        check("t5c_rst_misc", {ovf, cause, cyc}, 64'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // 6: stalled drain with ready pattern 1,0,0,1
        break_pc = 32'h214;
        do_arm();
        for (int i = 0; i < 6; i++) commit(32'(32'h200 + 4 * i), 16'(i), 1'b1);
        check("t6_count", 64'(cnt), 64'd6);
        drain(4'b1001, "t6");
        check("t6_count_after", 64'(cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sm_trace_monitor.md
Name: sm_trace_monitor

Overview:
Synthesizable per-commit trace monitor for the schoolRISCV core, instantiated beside sm_cpu inside sm_top. Captures {cycle stamp, pc, instr, a0} on every committed instruction into a circular buffer. Stops capture on a timeout, a branch-to-self halt, or a PC breakpoint. After stopping, it drains the captured trace oldest-first through a valid/ready port for a debug host or a bench scoreboard.

Parameters:
DEPTH, 16, trace entries; power of 2, >= 2
PC_WIDTH, 32, width of pc
DATA_WIDTH, 32, width of instr and a0
CYCLE_WIDTH, 16, width of cycle stamp/counter
TIMEOUT_CYCLES, 120, RUN clocks before timeout stop; 0 disables timeout
STALL_LIMIT, 4, consecutive repeated-pc commits that signal halt; 0 disables

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
commit_valid  in  1  one instruction committed this cycle
commit_pc  in  PC_WIDTH  pc of committed instruction
commit_instr  in  DATA_WIDTH  instruction word
commit_a0  in  DATA_WIDTH  current rf[10] value
arm  in  1  IDLE->RUN request, single-cycle pulse
clear  in  1  synchronous return to IDLE, flushes buffer
break_en  in  1  enables PC breakpoint
break_pc  in  PC_WIDTH  breakpoint address
out_valid  out  1  trace entry available
out_ready  in  1  consumer accepts entry
out_cycle  out  CYCLE_WIDTH  stamp of head entry
out_pc  out  PC_WIDTH  pc of head entry
out_instr  out  DATA_WIDTH  instr of head entry
out_a0  out  DATA_WIDTH  a0 of head entry
state  out  2  IDLE=0, RUN=1, STOPPED=2
stop_cause  out  2  NONE=0, TIMEOUT=1, HALT=2, BREAK=3
count  out  $clog2(DEPTH)+1  valid entries in buffer
overflow  out  1  sticky: an entry was overwritten
cycle  out  CYCLE_WIDTH  RUN clock counter

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: state=IDLE, stop_cause=0, count=0, overflow=0, cycle=0, pointers=0, repeat counter=0, out_valid=0. All out_* data outputs read 0.
- Priority: clear beats arm on the same edge. clear from any state -> IDLE with the same register values as reset (memory contents are don't-care).
- IDLE: no capture. arm=1 -> RUN with cycle=0. commit_valid is ignored.
- RUN, counter: cycle increments by 1 every clk, independent of commit_valid.
- RUN, capture: on commit_valid, write {cycle, commit_pc, commit_instr, commit_a0} at wr_ptr and advance wr_ptr mod DEPTH. The stamp is the pre-increment cycle value.
- RUN, full buffer: count saturates at DEPTH; rd_ptr advances with wr_ptr (oldest entry overwritten); overflow set.
- Timeout: on the edge where cycle would become TIMEOUT_CYCLES, cycle takes that value, state -> STOPPED, cause=TIMEOUT.
- Halt detect:
  - a commit whose pc equals the previously committed pc increments the repeat counter; any other commit resets it to 0; the first commit after arm never counts as a repeat.
  - when the counter reaches STALL_LIMIT: STOPPED, cause=HALT.
- Breakpoint: break_en & commit_valid & commit_pc==break_pc -> STOPPED, cause=BREAK.
- Stopping commit: the commit that triggers a stop is itself captured. If several stop conditions hold on one edge: BREAK > HALT > TIMEOUT.
- STOPPED: capture and cycle are frozen; arm is ignored.
- Read port:
  - out_valid = (state==STOPPED) && count!=0.
  - out_* show the entry at rd_ptr combinationally (show-ahead) and stay stable while out_valid & !out_ready.
  - pop on out_valid & out_ready: rd_ptr+1 mod DEPTH, count-1. Zero-latency next entry.
  - out_valid is 0 the cycle after the last pop. out_valid is never 1 in IDLE or RUN.
  - STOPPED persists after the drain until clear.
- Reset asserted mid-RUN or mid-drain: immediate return to reset values, regardless of clk.
- Widths: cycle wraps modulo 2^CYCLE_WIDTH when TIMEOUT_CYCLES=0; pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Package sm_trace_pkg: state encodings (IDLE/RUN/STOPPED), stop_cause encodings (NONE/TIMEOUT/HALT/BREAK), entry-width helper constant.
- Sub-module sm_trace_buf: circular register-array buffer with wr/rd pointers, count, overwrite-on-full and overflow flag.
- Top module: FSM, cycle counter, halt/break/timeout detection.

Test Plan:
1. arm; commits pc 0x0,0x4,0x8,0xC,0x10 on consecutive clocks; break_en=1, break_pc=0x10 -> STOPPED, cause=3, count=5; drain with out_ready=1 yields pcs 0x0..0x10 in order, stamps 0..4.
2. DEPTH=16; 20 commits pc=4*i (i=0..19), break_pc=0x4C -> count=16, overflow=1; first out_pc=0x10, last out_pc=0x4C.
3. TIMEOUT_CYCLES=120; arm, commit_valid held 0 -> STOPPED after 120 RUN clocks, cause=1, cycle=120, count=0, out_valid=0.
4. STALL_LIMIT=4; commits pc 0x8 then five commits at 0x20 -> stop on the 5th 0x20 commit, cause=2, count=6; an intervening 0x24 commit resets the repeat count (no stop).
5. Breakpoint commit on the same edge as the timeout edge -> cause=3; clear and arm on the same edge -> IDLE; rst_n pulsed low mid-drain -> all outputs 0 asynchronously.
6. Drain with out_ready toggling 1,0,0,1 -> out_pc held stable during stalls, exactly one pop per accepted handshake, out_valid drops the cycle after the final pop.
